// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FSM states, fp32 field widths and constants
package fp_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  localparam logic [FP_W-1:0] ZERO = '0;
endpackage

// File: rtl/fp_addsub_arbiter_unit.sv
// rtl/fp_addsub_arbiter_unit.sv - combinational fp32 add/sub, truncating, no special-value handling
module fp_addsub_arbiter_unit
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  output logic [FP_W-1:0] y
);
  logic                a_big;
  logic                sign_big;
  logic                sign_small;
  logic [FP_EXP_W-1:0] exp_big;
  logic [FP_EXP_W-1:0] exp_small;
  logic [FP_EXP_W-1:0] exp_diff;
  logic [FP_MAN_W:0]   man_big;
  logic [FP_MAN_W:0]   man_small;
  logic [FP_MAN_W:0]   man_shift;
  logic [FP_MAN_W+1:0] sum;
  logic [FP_MAN_W:0]   norm;
  logic [4:0]          lz;
  logic                found;

  always_comb begin
    // Larger magnitude operand supplies the result sign and the alignment exponent.
    a_big      = a[FP_W-2:0] >= b[FP_W-2:0];
    sign_big   = a_big ? a[FP_W-1] : (b[FP_W-1] ^ sub);
    sign_small = a_big ? (b[FP_W-1] ^ sub) : a[FP_W-1];
    exp_big    = a_big ? a[FP_W-2 -: FP_EXP_W] : b[FP_W-2 -: FP_EXP_W];
    exp_small  = a_big ? b[FP_W-2 -: FP_EXP_W] : a[FP_W-2 -: FP_EXP_W];
    man_big    = {1'b1, (a_big ? a[FP_MAN_W-1:0] : b[FP_MAN_W-1:0])};
    man_small  = {1'b1, (a_big ? b[FP_MAN_W-1:0] : a[FP_MAN_W-1:0])};
    exp_diff   = exp_big - exp_small;
    man_shift  = man_small >> exp_diff;

    if (sign_big ^ sign_small)
      sum = {1'b0, man_big} - {1'b0, man_shift};
    else
      sum = {1'b0, man_big} + {1'b0, man_shift};

    lz    = '0;
    found = 1'b0;
    for (int i = FP_MAN_W; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz    = 5'(FP_MAN_W - i);
      end
    end
    norm = sum[FP_MAN_W:0] << lz;

    y = ZERO;
    if (sum == '0)
      y = ZERO;
    else if (sum[FP_MAN_W+1])
      y = {sign_big, exp_big + 8'd1, sum[FP_MAN_W:1]};
    else
      y = {sign_big, exp_big - FP_EXP_W'(lz), norm[FP_MAN_W-1:0]};
  end
endmodule

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - N requesters sharing one fp32 add/sub unit via IDLE/EXEC/RESP FSM
// Define FPAS_FIXED_PRIO_EN for fixed-priority (lowest index) arbitration; default is round-robin.
module fp_addsub_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  input  logic [N_REQ-1:0]   req_sub,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);
  state_t          state_q, state_d;
  logic [FP_W-1:0] a_q, a_d;
  logic [FP_W-1:0] b_q, b_d;
  logic            sub_q, sub_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [FP_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [FP_W-1:0] unit_y;
  logic [IDW-1:0]  grant_id;
  logic [FP_W-1:0] sel_a;
  logic [FP_W-1:0] sel_b;
  logic            sel_sub;
  logic            any_valid;
  logic            accept;

`ifndef FPAS_FIXED_PRIO_EN
  logic [IDW-1:0]  last_grant_q, last_grant_d;
`endif

  always_comb begin
    grant_id = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req_valid[i]) grant_id = IDW'(i);
`ifndef FPAS_FIXED_PRIO_EN
    // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid overall.
    for (int i = N_REQ-1; i >= 0; i--)
      if (req_valid[i] && (IDW'(i) > last_grant_q)) grant_id = IDW'(i);
`endif
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a   = req_a[i*32 +: 32];
        sel_b   = req_b[i*32 +: 32];
        sel_sub = req_sub[i];
      end
    end
  end

  assign any_valid = |req_valid;
  assign accept    = !rst && any_valid &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = accept && (grant_id == IDW'(i));
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifndef FPAS_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        rsp_data_d = unit_y;
        rsp_id_d   = id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: if (rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d   = sel_a;
      b_d   = sel_b;
      sub_d = sel_sub;
      id_d  = grant_id;
`ifndef FPAS_FIXED_PRIO_EN
      last_grant_d = grant_id;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= ZERO;
      b_q        <= ZERO;
      sub_q      <= 1'b0;
      id_q       <= '0;
      rsp_data_q <= ZERO;
      rsp_id_q   <= '0;
`ifndef FPAS_FIXED_PRIO_EN
      last_grant_q <= IDW'(N_REQ-1);
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
`ifndef FPAS_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  fp_addsub_arbiter_unit u_unit (
    .a   (a_q),
    .b   (b_q),
    .sub (sub_q),
    .y   (unit_y)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb/tb_fp_addsub_arbiter.sv - directed self-checking bench for fp_addsub_arbiter
module tb_fp_addsub_arbiter;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*32-1:0]   req_a;
  logic [N_REQ*32-1:0]   req_b;
  logic [N_REQ-1:0]      req_sub;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_valid[i]       = 1'b1;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_sub[i]         = sub;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_op(input string name, input int i, input logic [31:0] a,
                                input logic [31:0] b, input logic sub, input logic [31:0] exp_data);
    logic [N_REQ-1:0] exp_rdy;
    exp_rdy    = '0;
    exp_rdy[i] = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy: got %b expected 0", name, busy); end
    drive_req(i, a, b, sub);
    #1;
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL %s_req_ready: got %b expected %b", name, req_ready, exp_rdy); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_exec: got rsp_valid=%b busy=%b expected 0/1", name, rsp_valid, busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_rsp_valid: got %b expected 1", name, rsp_valid); end
    checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL %s_rsp_data: got %h expected %h", name, rsp_data, exp_data); end
    checks++; if (rsp_id !== IDW'(i)) begin errors++; $display("FAIL %s_rsp_id: got %0d expected %0d", name, rsp_id, i); end
  endtask

  task automatic test_back_to_back;
    int exp_id [5];
    logic [N_REQ-1:0] exp_rdy;
`ifdef FPAS_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0, 0};
`else
    exp_id = '{0, 1, 2, 3, 0};
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) drive_req(i, 32'h3F800000, 32'h40000000, 1'b0);
    #1;
    exp_rdy = '0; exp_rdy[exp_id[0]] = 1'b1;
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_first_grant: got %b expected %b", req_ready, exp_rdy); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL b2b_exec_%0d: got req_ready=%b busy=%b expected 0000/1", k, req_ready, busy); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id[k])) begin errors++; $display("FAIL b2b_rsp_%0d: got valid=%b id=%0d expected 1/%0d", k, rsp_valid, rsp_id, exp_id[k]); end
      checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL b2b_data_%0d: got %h expected 40400000", k, rsp_data); end
      if (k < 4) begin
        exp_rdy = '0; exp_rdy[exp_id[k+1]] = 1'b1;
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_grant_%0d: got %b expected %b", k+1, req_ready, exp_rdy); end
      end else begin
        req_valid = '0;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [N_REQ-1:0] exp_rdy;
    int exp_next;
`ifdef FPAS_FIXED_PRIO_EN
    exp_next = 0;
`else
    exp_next = 3;
`endif
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(1, 32'hC0000000, 32'h3F800000, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    drive_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    drive_req(3, 32'h3F800000, 32'h40000000, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_exec_ready: got %b expected 0000", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hBF800000 || rsp_id !== 2'd1) begin
        errors++; $display("FAIL bp_stall_%0d: got valid=%b data=%h id=%0d expected 1/bf800000/1", c, rsp_valid, rsp_data, rsp_id);
      end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready_%0d: got %b expected 0000", c, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    exp_rdy = '0; exp_rdy[exp_next] = 1'b1;
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL bp_release_grant: got %b expected %b", req_ready, exp_rdy); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_exec_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_next) || rsp_data !== 32'h40400000) begin
      errors++; $display("FAIL bp_next_rsp: got valid=%b id=%0d data=%h expected 1/%0d/40400000", rsp_valid, rsp_id, rsp_data, exp_next);
    end
  endtask

  task automatic test_reset_exec;
    @(negedge clk);
    drive_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstx_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstx_exec_busy: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rstx_async: got valid=%b data=%h id=%0d busy=%b ready=%b expected all 0", rsp_valid, rsp_data, rsp_id, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstx_quiet_%0d: got valid=%b busy=%b expected 0/0", c, rsp_valid, busy); end
    end
    @(negedge clk);
    drive_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    drive_req(1, 32'h3F800000, 32'h40000000, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstx_prio_after_reset: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h40400000) begin
      errors++; $display("FAIL rstx_new_rsp: got valid=%b id=%0d data=%h expected 1/0/40400000", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_op("add_1p2",   0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    test_single_op("cancel",    2, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000);
    test_single_op("mixed_sgn", 1, 32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000);
    test_single_op("carry",     3, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000);
    test_single_op("sub_small", 0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);
    test_back_to_back;
    test_backpressure;
    test_reset_exec;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
